prog_launch_ctl: RTL and testbench

Front-end program launcher for the processor labkit. It debounces NBTN push-buttons and converts a rising edge on any of them into a program-selector value that is held for a guaranteed number of cycles, so the register file can copy the selected program. It then tracks the run until the processor signals completion. It replaces the ad-hoc single-button selector logic in the labkit top level and drives the regfile's program_selector input.

---
 rtl/prog_ctl_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 56 +++++
 rtl/prog_launch_ctl.sv | 133 +++++++++++++
 tb/tb_prog_launch_ctl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctl_pkg.sv
// Shared types and width helpers for the program launcher.
package prog_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN
  } state_e;

  // Program ids run 1..nbtn, with 0 meaning "no program".
  function automatic int prog_id_w(input int nbtn);
    return $clog2(nbtn) + 1;
  endfunction

  // Counter width for a counter that runs 0..n-1, never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and rise detector.
module debounce_ch
  import prog_ctl_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic          db_prev_q, db_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    cnt_d     = '0;
    // Counter only advances while the synchronised level disagrees.
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rise = db_q & ~db_prev_q;

endmodule

// File: rtl/prog_launch_ctl.sv
// Debounced push-button program launcher driving the regfile program selector.
module prog_launch_ctl
  import prog_ctl_pkg::*;
#(
  parameter int NBTN        = 4,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int SEL_W       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NBTN-1:0]            btn,
  input  logic                       done,
  output logic [SEL_W-1:0]           program_selector,
  output logic                       launch,
  output logic                       busy,
  output logic [prog_id_w(NBTN)-1:0] active_prog,
  output logic                       dropped
);

  localparam int ID_W = prog_id_w(NBTN);
  localparam int HCW  = cnt_w(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  logic [NBTN-1:0] rise;
  logic            any_rise;
  logic [ID_W-1:0] pick_id;

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clock),
      .rst    (reset),
      .btn_raw(btn[g]),
      .rise   (rise[g])
    );
  end

  assign any_rise = |rise;

  always_comb begin
    logic found;
    found   = 1'b0;
    pick_id = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (rise[i] && !found) begin
        found   = 1'b1;
        pick_id = ID_W'(i + 1);
      end
    end
  end

  state_e          state_q, state_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [ID_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0] act_q, act_d;
  logic            launch_q, launch_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    sel_d    = sel_q;
    act_d    = act_q;
    launch_d = 1'b0;
    busy_d   = busy_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        // Lower-index rises win; the losers are discarded without flagging.
        if (any_rise) begin
          state_d  = HOLD;
          hold_d   = '0;
          sel_d    = pick_id;
          act_d    = pick_id;
          launch_d = 1'b1;
          busy_d   = 1'b1;
          drop_d   = 1'b0;
        end
      end
      HOLD: begin
        if (any_rise) drop_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          sel_d   = '0;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      RUN: begin
        if (any_rise) drop_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      sel_q    <= '0;
      act_q    <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      sel_q    <= sel_d;
      act_q    <= act_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign program_selector = SEL_W'(sel_q);
  assign launch           = launch_q;
  assign busy             = busy_q;
  assign active_prog      = act_q;
  assign dropped          = drop_q;

endmodule

// File: tb/tb_prog_launch_ctl.sv
// Directed plus randomized bench for prog_launch_ctl against a cycle reference model.
module tb_prog_launch_ctl;

  localparam int NBTN        = 4;
  localparam int DB_CYCLES   = 4;
  localparam int HOLD_CYCLES = 3;
  localparam int SEL_W       = 32;
  localparam int ID_W        = $clog2(NBTN) + 1;

  logic              clock;
  logic              reset;
  logic [NBTN-1:0]   btn;
  logic              done;
  logic [SEL_W-1:0]  program_selector;
  logic              launch;
  logic              busy;
  logic [ID_W-1:0]   active_prog;
  logic              dropped;

  int total = 0;
  int bad   = 0;

  prog_launch_ctl #(
    .NBTN       (NBTN),
    .DB_CYCLES  (DB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .SEL_W      (SEL_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .btn             (btn),
    .done            (done),
    .program_selector(program_selector),
    .launch          (launch),
    .busy            (busy),
    .active_prog     (active_prog),
    .dropped         (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: btn seen two edges late, a level flips after DB_CYCLES
  // consecutive disagreeing samples, launcher modes 0=idle 1=hold 2=run.
  bit [NBTN-1:0] m_p1, m_p2, m_deb, m_prev;
  int            m_run [NBTN];
  int            m_mode, m_hold_left;
  int            m_sel, m_act;
  bit            m_launch, m_busy, m_drop;

  task automatic m_reset();
    m_p1 = '0; m_p2 = '0; m_deb = '0; m_prev = '0;
    for (int i = 0; i < NBTN; i++) m_run[i] = 0;
    m_mode = 0; m_hold_left = 0;
    m_sel = 0; m_act = 0;
    m_launch = 0; m_busy = 0; m_drop = 0;
  endtask

  task automatic m_step();
    bit [NBTN-1:0] r;
    int id;
    r = m_deb & ~m_prev;
    m_launch = 0;
    if (m_mode == 0) begin
      if (r != 0) begin
        id = 0;
        for (int i = 0; i < NBTN; i++) if (r[i]) begin id = i + 1; break; end
        m_mode = 1; m_hold_left = HOLD_CYCLES - 1;
        m_sel = id; m_act = id; m_launch = 1; m_busy = 1; m_drop = 0;
      end
    end else if (m_mode == 1) begin
      if (r != 0) m_drop = 1;
      if (m_hold_left == 0) begin m_mode = 2; m_sel = 0; end
      else m_hold_left--;
    end else begin
      if (r != 0) m_drop = 1;
      if (done) begin m_mode = 0; m_busy = 0; end
    end
    m_prev = m_deb;
    for (int i = 0; i < NBTN; i++) begin
      if (m_p2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB_CYCLES) begin m_deb[i] = m_p2[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_p2 = m_p1;
    m_p1 = btn;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("sel",    program_selector, 32'(m_sel));
    check("launch", 32'(launch),      32'(m_launch));
    check("busy",   32'(busy),        32'(m_busy));
    check("act",    32'(active_prog), 32'(m_act));
    check("drop",   32'(dropped),     32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) m_reset(); else m_step();
    @(negedge clock);
    compare_model();
  endtask

  task automatic wait_launch(input int budget, output int n);
    n = 0;
    while (launch !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("launch_wait", 32'(launch), 32'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, seg;
    bit [NBTN-1:0] target;

    reset = 1'b1; btn = '0; done = 1'b0;
    m_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_sel",  program_selector, 32'd0);
    check("rst_busy", 32'(busy),        32'd0);
    check("rst_act",  32'(active_prog), 32'd0);
    check("rst_drop", 32'(dropped),     32'd0);

    // Single launch; latency counted from the edge that first samples the press.
    btn = 4'b0001;
    tick();
    wait_launch(20, n);
    check("lat0", 32'(n), 32'(2 + DB_CYCLES));
    check("sel0", program_selector, 32'd1);
    cnt = 0;
    while (program_selector != 0 && cnt < 10) begin cnt++; tick(); end
    check("hold_len", 32'(cnt), 32'(HOLD_CYCLES));
    check("busy_run", 32'(busy), 32'd1);
    repeat (10) tick();
    btn = '0;
    repeat (8) tick();
    check("busy_before_done", 32'(busy), 32'd1);
    pulse_done();
    check("busy_idle", 32'(busy),        32'd0);
    check("act_keep",  32'(active_prog), 32'd1);

    // Bounce rejection on channel 1.
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      btn = ((k / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      if (launch) cnt++;
    end
    check("bounce_nolaunch", 32'(cnt), 32'd0);
    btn = 4'b0010;
    wait_launch(20, n);
    check("bounce_sel", program_selector, 32'd2);
    repeat (4) tick();
    btn = '0;
    repeat (8) tick();
    pulse_done();

    // Same-cycle press on channels 1 and 2: lower index wins, nothing dropped.
    btn = 4'b0110;
    wait_launch(20, n);
    check("prio_sel",  program_selector, 32'd2);
    check("prio_drop", 32'(dropped),     32'd0);
    repeat (5) tick();
    check("prio_drop_run", 32'(dropped), 32'd0);
    btn = '0;
    repeat (8) tick();
    pulse_done();

    // Press while busy sets dropped; the next launch clears it.
    btn = 4'b0001;
    wait_launch(20, n);
    btn = '0;
    repeat (5) tick();
    btn = 4'b1000;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (launch) cnt++; end
    check("busy_nolaunch", 32'(cnt),     32'd0);
    check("drop_set",      32'(dropped), 32'd1);
    btn = '0;
    repeat (10) tick();
    pulse_done();
    check("drop_sticky", 32'(dropped), 32'd1);
    btn = 4'b0001;
    wait_launch(20, n);
    check("drop_clr", 32'(dropped), 32'd0);
    btn = '0;
    repeat (10) tick();
    pulse_done();

    // Reset on the second HOLD cycle with the button still held.
    btn = 4'b0001;
    wait_launch(20, n);
    tick();
    check("hold2_sel", program_selector, 32'd1);
    reset = 1'b1;
    m_reset();
    #1;
    check("rst_async_sel",  program_selector, 32'd0);
    check("rst_async_busy", 32'(busy),        32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    wait_launch(20, n);
    check("relaunch_lat", 32'(n), 32'(2 + DB_CYCLES));
    check("relaunch_sel", program_selector, 32'd1);
    btn = '0;
    repeat (10) tick();
    pulse_done();

    // Randomized traffic with bounces, done pulses and occasional resets.
    seg = 0;
    target = '0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        seg = $urandom_range(6, 40);
        target = NBTN'($urandom);
      end
      seg--;
      btn   = ($urandom_range(0, 7) == 0) ? target ^ NBTN'(1 << $urandom_range(0, NBTN - 1)) : target;
      done  = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; done = 1'b0; btn = '0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
